// File: rtl/envelope_bank.sv
// rtl/envelope_bank.sv - time-shared biquad vocoder envelope follower bank
module envelope_bank #(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 32,
    parameter int BPF_SHIFT = 20,
    parameter int LPF_SHIFT = 8,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] x_in,
    output logic                     ready_out,
    input  logic                     coef_wr_in,
    input  logic [CH_W-1:0]          coef_ch_in,
    input  logic [4:0]               coef_idx_in,
    input  logic signed [DATA_W-1:0] coef_data_in,
    output logic signed [DATA_W-1:0] env_out,
    output logic [CH_W-1:0]          env_ch_out,
    output logic                     env_valid_out,
    output logic                     done_out,
    output logic                     overrun_out,
    input  logic                     clr_ovr_in
);
    localparam int SUM_W = 2 * DATA_W + 3;

    typedef enum logic [2:0] {S_IDLE, S_BPF0, S_BPF1, S_LPF0, S_LPF1} state_t;

    state_t                   r_state, w_state_next;
    logic [CH_W-1:0]          r_ch, r_env_ch;
    logic signed [DATA_W-1:0] r_x, r_stage, r_env;
    logic                     r_ovr;
    logic signed [DATA_W-1:0] r_coef [NUM_CH][20];
    logic signed [DATA_W-1:0] r_u1 [NUM_CH][4];
    logic signed [DATA_W-1:0] r_u2 [NUM_CH][4];
    logic signed [DATA_W-1:0] r_y1 [NUM_CH][4];
    logic signed [DATA_W-1:0] r_y2 [NUM_CH][4];

    logic [1:0]               w_sec;
    logic [4:0]               w_base;
    logic                     w_busy, w_accept, w_last_ch, w_coef_we;
    logic signed [DATA_W-1:0] w_rect, w_u, w_y;
    logic signed [DATA_W-1:0] w_b0, w_b1, w_b2, w_a1, w_a2;
    logic signed [SUM_W-1:0]  w_sum;

    function automatic logic signed [2*DATA_W-1:0] sx(input logic signed [DATA_W-1:0] v);
        return {{DATA_W{v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [SUM_W-1:0] sxp(input logic signed [2*DATA_W-1:0] v);
        return {{3{v[2*DATA_W-1]}}, v};
    endfunction

    assign w_busy    = (r_state != S_IDLE);
    assign ready_out = !w_busy;
    assign w_accept  = valid_in && ready_out;
    assign w_last_ch = (r_ch == CH_W'(NUM_CH - 1));
    assign w_coef_we = coef_wr_in && ready_out && (coef_idx_in < 5'd20);

    always_comb begin
        w_sec = 2'd0;
        case (r_state)
            S_BPF1:  w_sec = 2'd1;
            S_LPF0:  w_sec = 2'd2;
            S_LPF1:  w_sec = 2'd3;
            default: w_sec = 2'd0;
        endcase
    end

    // Rectifier saturates the most-negative value instead of wrapping it back negative.
    always_comb begin
        w_rect = r_stage;
        if (r_stage == {1'b1, {(DATA_W-1){1'b0}}})
            w_rect = {1'b0, {(DATA_W-1){1'b1}}};
        else if (r_stage[DATA_W-1])
            w_rect = -r_stage;
    end

    always_comb begin
        w_u = r_stage;
        case (w_sec)
            2'd0:    w_u = r_x;
            2'd2:    w_u = w_rect;
            default: w_u = r_stage;
        endcase
    end

    assign w_base = {3'b000, w_sec} * 5'd5;
    assign w_b0   = r_coef[r_ch][w_base];
    assign w_b1   = r_coef[r_ch][w_base + 5'd1];
    assign w_b2   = r_coef[r_ch][w_base + 5'd2];
    assign w_a1   = r_coef[r_ch][w_base + 5'd3];
    assign w_a2   = r_coef[r_ch][w_base + 5'd4];

    assign w_sum = sxp(sx(w_b0) * sx(w_u))
                 + sxp(sx(w_b1) * sx(r_u1[r_ch][w_sec]))
                 + sxp(sx(w_b2) * sx(r_u2[r_ch][w_sec]))
                 - sxp(sx(w_a1) * sx(r_y1[r_ch][w_sec]))
                 - sxp(sx(w_a2) * sx(r_y2[r_ch][w_sec]));

    assign w_y = DATA_W'(w_sec[1] ? (w_sum >>> LPF_SHIFT) : (w_sum >>> BPF_SHIFT));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (valid_in) w_state_next = S_BPF0;
            S_BPF0:  w_state_next = S_BPF1;
            S_BPF1:  w_state_next = S_LPF0;
            S_LPF0:  w_state_next = S_LPF1;
            S_LPF1:  w_state_next = w_last_ch ? S_IDLE : S_BPF0;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ch     <= '0;
            r_x      <= '0;
            r_stage  <= '0;
            r_env    <= '0;
            r_env_ch <= '0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ch <= '0;
                r_x  <= x_in;
            end else if (r_state == S_LPF1 && !w_last_ch) begin
                r_ch <= r_ch + CH_W'(1);
            end
            if (w_busy) r_stage <= w_y;
            if (r_state == S_LPF1) begin
                r_env    <= w_y;
                r_env_ch <= r_ch;
            end
            if (valid_in && !ready_out) r_ovr <= 1'b1;
            else if (clr_ovr_in)        r_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < 20; k++)
                    r_coef[c][k] <= '0;
        end else if (w_coef_we) begin
            r_coef[coef_ch_in][coef_idx_in] <= coef_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int s = 0; s < 4; s++) begin
                    r_u1[c][s] <= '0;
                    r_u2[c][s] <= '0;
                    r_y1[c][s] <= '0;
                    r_y2[c][s] <= '0;
                end
        end else if (w_busy) begin
            r_u2[r_ch][w_sec] <= r_u1[r_ch][w_sec];
            r_u1[r_ch][w_sec] <= w_u;
            r_y2[r_ch][w_sec] <= r_y1[r_ch][w_sec];
            r_y1[r_ch][w_sec] <= w_y;
        end
    end

    // The band result is presented combinationally during its final section cycle.
    assign env_valid_out = (r_state == S_LPF1);
    assign done_out      = env_valid_out && w_last_ch;
    assign env_out       = env_valid_out ? w_y : r_env;
    assign env_ch_out    = env_valid_out ? r_ch : r_env_ch;
    assign overrun_out   = r_ovr;
endmodule

// File: tb/tb_envelope_bank.sv
// tb/tb_envelope_bank.sv - scoreboard bench for envelope_bank
module tb_envelope_bank;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 32;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              valid_in;
    logic [DATA_W-1:0] x_in;
    logic              ready_out;
    logic              coef_wr_in;
    logic [2:0]        coef_ch_in;
    logic [4:0]        coef_idx_in;
    logic [DATA_W-1:0] coef_data_in;
    logic [DATA_W-1:0] env_out;
    logic [2:0]        env_ch_out;
    logic              env_valid_out;
    logic              done_out;
    logic              overrun_out;
    logic              clr_ovr_in;

    envelope_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BPF_SHIFT(20), .LPF_SHIFT(8)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .x_in(x_in),
        .ready_out(ready_out), .coef_wr_in(coef_wr_in), .coef_ch_in(coef_ch_in),
        .coef_idx_in(coef_idx_in), .coef_data_in(coef_data_in), .env_out(env_out),
        .env_ch_out(env_ch_out), .env_valid_out(env_valid_out), .done_out(done_out),
        .overrun_out(overrun_out), .clr_ovr_in(clr_ovr_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] env;
        logic        done;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] exp_env [NUM_CH];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          t_acc;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_n_in && env_valid_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_env_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("env_out", env_out, mon_e.env);
                chk("env_ch_out", env_ch_out, mon_e.ch);
                chk("done_out", done_out, mon_e.done);
                chk("env_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic wr(input int ch, input int idx, input logic [31:0] d);
        coef_wr_in = 1'b1; coef_ch_in = ch[2:0]; coef_idx_in = idx[4:0]; coef_data_in = d;
        @(posedge clk_in); #1;
        coef_wr_in = 1'b0;
    endtask

    task automatic load_pt();
        for (int c = 0; c < NUM_CH; c++) begin
            wr(c, 0, 32'd1 << 20);
            wr(c, 5, 32'd1 << 20);
            wr(c, 10, 32'd256);
            wr(c, 15, 32'd256);
        end
    endtask

    task automatic set_exp(input logic [31:0] v);
        for (int c = 0; c < NUM_CH; c++) exp_env[c] = v;
    endtask

    task automatic send(input logic [31:0] x);
        exp_t e;
        chk("ready_before_send", ready_out, 1'b1);
        valid_in = 1'b1; x_in = x;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        t_acc = cyc;
        for (int c = 0; c < NUM_CH; c++) begin
            e.ch = c[2:0]; e.env = exp_env[c]; e.done = (c == NUM_CH - 1);
            e.cyc = t_acc + 4 * c + 3;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !ready_out) && n < 300) begin
            @(posedge clk_in); #1; n++;
        end
        chk("wait_idle_timeout", n < 300, 1'b1);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
    endtask

    initial begin
        rst_n_in = 1'b0; valid_in = 1'b0; x_in = '0; coef_wr_in = 1'b0;
        coef_ch_in = '0; coef_idx_in = '0; coef_data_in = '0; clr_ovr_in = 1'b0;
        repeat (3) @(posedge clk_in); #1;
        chk("rst_ready", ready_out, 1'b1);
        chk("rst_env", env_out, 32'd0);
        chk("rst_env_ch", env_ch_out, 3'd0);
        chk("rst_env_valid", env_valid_out, 1'b0);
        chk("rst_done", done_out, 1'b0);
        chk("rst_overrun", overrun_out, 1'b0);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        // Pass-through, then a too-early and an on-time second sample.
        load_pt();
        set_exp(32'd1000);
        send(-32'sd1000);
        chk("busy_after_accept", ready_out, 1'b0);
        while (cyc < t_acc + 31) begin @(posedge clk_in); #1; end
        chk("busy_at_last_band", ready_out, 1'b0);
        valid_in = 1'b1; x_in = -32'sd2000;
        @(posedge clk_in); #1;
        chk("overrun_early", overrun_out, 1'b1);
        chk("ready_after_last", ready_out, 1'b1);
        set_exp(32'd2000);
        send(-32'sd2000);
        chk("busy_second", ready_out, 1'b0);
        valid_in = 1'b1; clr_ovr_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0; clr_ovr_in = 1'b0;
        chk("overrun_set_wins", overrun_out, 1'b1);
        clr_ovr_in = 1'b1;
        @(posedge clk_in); #1;
        clr_ovr_in = 1'b0;
        chk("overrun_cleared", overrun_out, 1'b0);
        wr(0, 0, 32'd0);
        wr(3, 15, 32'd0);
        wait_idle();

        // Saturating rectifier and held output.
        set_exp(32'h7FFF_FFFF);
        send(32'h8000_0000);
        wait_idle();
        chk("env_hold", env_out, 32'h7FFF_FFFF);
        chk("env_ch_hold", env_ch_out, 3'd7);

        // Writes issued while busy must not have landed.
        set_exp(32'd7);
        send(-32'sd7);
        wr(1, 10, 32'd0);
        wait_idle();
        set_exp(32'd123);
        send(32'd123);
        wait_idle();

        // Reset in the middle of a sample.
        set_exp(32'd1000);
        send(-32'sd1000);
        repeat (9) @(posedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        sb.delete();
        chk("midrst_env_valid", env_valid_out, 1'b0);
        chk("midrst_done", done_out, 1'b0);
        chk("midrst_env", env_out, 32'd0);
        chk("midrst_env_ch", env_ch_out, 3'd0);
        chk("midrst_ready", ready_out, 1'b1);
        chk("midrst_overrun", overrun_out, 1'b0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        repeat (40) @(posedge clk_in);
        #1;
        load_pt();
        send(-32'sd1000);
        wait_idle();

        // Per-band history: band 0 first section uses only the delayed input.
        do_reset();
        load_pt();
        wr(0, 0, 32'd0);
        wr(0, 1, 32'd1 << 20);
        set_exp(32'd10000);
        exp_env[0] = 32'd0;
        send(32'd10000);
        wait_idle();
        set_exp(32'd0);
        exp_env[0] = 32'd10000;
        send(32'd0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
